// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
// Sequencer for a DEPTH-entry x DW-bit weight buffer. A load phase writes a
// valid/ready stream of rows into the buffer; a replay phase reads the stored
// rows back one or more times for the systolic array. Every buffer pin is
// driven from a register, and a valid/last/row sideband is produced that lines
// up with the buffer's registered Q output (one edge after the read issue).
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   cmd_load, load_len          start a load of load_len rows (clamped to DEPTH)
//   ld_valid, ld_ready, ld_data load row stream
//   load_done                   one-cycle pulse when the load phase ends
//   cmd_run, run_len,           start replay: run_len rows per pass,
//   run_passes, run_opstage     run_passes passes (0 = 1), opstage for the run
//   hold                        downstream stall, suspends read issue
//   run_done                    one-cycle pulse, coincident with the final q_valid
//   busy                        controller is not idle
//   q_valid, q_last, q_row      sideband describing the buffer's current Q
//   WB_CEN, WB_WEN, WB_A, WB_D,
//   WB_OPSTAGE, WB_RETN         weight buffer control pins
module weight_buffer_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 13,
  parameter int DW    = 512,
  parameter int LW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmd_load,
  input  logic [LW-1:0] load_len,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic          load_done,
  input  logic          cmd_run,
  input  logic [LW-1:0] run_len,
  input  logic [3:0]    run_passes,
  input  logic          run_opstage,
  input  logic          hold,
  output logic          run_done,
  output logic          busy,
  output logic          q_valid,
  output logic          q_last,
  output logic [LW-2:0] q_row,
  output logic          WB_CEN,
  output logic          WB_WEN,
  output logic [AW-1:0] WB_A,
  output logic [DW-1:0] WB_D,
  output logic          WB_OPSTAGE,
  output logic          WB_RETN
);

  // Row counter width; it indexes DEPTH entries, so it is one bit narrower
  // than the length fields that must be able to hold DEPTH itself.
  localparam int CW = LW - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic [3:0]    pass_cnt;
  logic [3:0]    pass_tot;
  logic [CW-1:0] wb_a_lo;
  logic          last_issue;

  logic [LW-1:0] load_len_c;
  logic [LW-1:0] run_len_c;
  logic [3:0]    run_passes_c;
  logic          row_end;
  logic          pass_end;

  // Command operand conditioning: lengths saturate at DEPTH, and a pass
  // count of zero is treated as a single pass. row_end/pass_end flag the
  // last row of the current pass and the last pass of the run.
  always_comb begin
    load_len_c   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    run_len_c    = (run_len > DEPTH_L) ? DEPTH_L : run_len;
    run_passes_c = (run_passes == 4'd0) ? 4'd1 : run_passes;
    row_end      = ({1'b0, cnt} == (len_q - LW'(1)));
    pass_end     = (pass_cnt == (pass_tot - 4'd1));
  end

  // Only the low address bits are ever used; the upper bits stay tied to 0.
  assign WB_A = {{(AW - CW){1'b0}}, wb_a_lo};

  // Main sequencer. Strobes (WEN, CEN, done pulses) default to inactive every
  // cycle so that they only last one cycle unless re-asserted. Reset also
  // serves as an abort: it returns to IDLE without any done pulse and leaves
  // CEN high so the buffer contents are never disturbed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      pass_cnt   <= '0;
      pass_tot   <= '0;
      wb_a_lo    <= '0;
      last_issue <= 1'b0;
      ld_ready   <= 1'b0;
      load_done  <= 1'b0;
      run_done   <= 1'b0;
      busy       <= 1'b0;
      WB_CEN     <= 1'b1;
      WB_WEN     <= 1'b1;
      WB_D       <= '0;
      WB_OPSTAGE <= 1'b0;
      WB_RETN    <= 1'b0;
    end else begin
      WB_RETN    <= 1'b1;
      load_done  <= 1'b0;
      run_done   <= 1'b0;
      WB_WEN     <= 1'b1;
      WB_CEN     <= 1'b1;
      last_issue <= 1'b0;
      case (state)
        S_IDLE: begin
          // Load has priority; a simultaneous run command is dropped.
          if (cmd_load) begin
            cnt <= '0;
            if (load_len_c == '0) begin
              load_done <= 1'b1;
            end else begin
              state    <= S_LOAD;
              busy     <= 1'b1;
              ld_ready <= 1'b1;
              len_q    <= load_len_c;
            end
          end else if (cmd_run) begin
            if (run_len_c == '0) begin
              run_done <= 1'b1;
            end else begin
              state      <= S_READ;
              busy       <= 1'b1;
              len_q      <= run_len_c;
              pass_tot   <= run_passes_c;
              pass_cnt   <= 4'd0;
              cnt        <= '0;
              WB_OPSTAGE <= run_opstage;
            end
          end
        end
        S_LOAD: begin
          // ld_ready low while still in LOAD marks the tail cycle after the
          // final write; that cycle closes the phase.
          if (ld_ready) begin
            if (ld_valid) begin
              WB_WEN  <= 1'b0;
              wb_a_lo <= cnt;
              WB_D    <= ld_data;
              cnt     <= cnt + CW'(1);
              if (row_end) begin
                ld_ready <= 1'b0;
              end
            end
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end
        end
        S_READ: begin
          // A held cycle issues nothing and freezes both counters.
          if (!hold) begin
            WB_CEN  <= 1'b0;
            wb_a_lo <= cnt;
            if (row_end) begin
              cnt <= '0;
              if (pass_end) begin
                last_issue <= 1'b1;
                state      <= S_DRAIN;
              end else begin
                pass_cnt <= pass_cnt + 4'd1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          // The final read's Q appears now, together with run_done.
          state    <= S_IDLE;
          busy     <= 1'b0;
          run_done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Q sideband: the buffer registers Q one edge after CEN/A, so the sideband
  // is simply the issued CEN/address/last-flag delayed by one edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q_row   <= '0;
    end else begin
      q_valid <= ~WB_CEN;
      q_last  <= last_issue & ~WB_CEN;
      q_row   <= wb_a_lo;
    end
  end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// tb_weight_buffer_ctrl
// Scoreboard bench for weight_buffer_ctrl. Stimulus tasks push the expected
// buffer writes and expected Q sideband entries into queues; a monitor running
// on the falling edge pops and compares whenever WB_WEN is low or q_valid is
// high. Phase-level properties (latency, pulse timing, cycle counts) are
// checked by the stimulus tasks from counters the monitor maintains.
module tb_weight_buffer_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 13;
  localparam int DW    = 512;
  localparam int LW    = 5;

  typedef struct packed {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic       last;
    logic [3:0] row;
  } q_exp_t;

  logic          CLK;
  logic          RST;
  logic          cmd_load;
  logic [LW-1:0] load_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          load_done;
  logic          cmd_run;
  logic [LW-1:0] run_len;
  logic [3:0]    run_passes;
  logic          run_opstage;
  logic          hold;
  logic          run_done;
  logic          busy;
  logic          q_valid;
  logic          q_last;
  logic [LW-2:0] q_row;
  logic          WB_CEN;
  logic          WB_WEN;
  logic [AW-1:0] WB_A;
  logic [DW-1:0] WB_D;
  logic          WB_OPSTAGE;
  logic          WB_RETN;

  int checks = 0;
  int errors = 0;

  wr_exp_t expWr[$];
  q_exp_t  expQ[$];

  int cycle       = 0;
  int wenLow      = 0;
  int cenLow      = 0;
  int qCount      = 0;
  int qFirst      = -1;
  int qLast       = -1;
  int loadDoneCnt = 0;
  int runDoneCnt  = 0;

  weight_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_load(cmd_load), .load_len(load_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .load_done(load_done),
    .cmd_run(cmd_run), .run_len(run_len), .run_passes(run_passes),
    .run_opstage(run_opstage), .hold(hold),
    .run_done(run_done), .busy(busy),
    .q_valid(q_valid), .q_last(q_last), .q_row(q_row),
    .WB_CEN(WB_CEN), .WB_WEN(WB_WEN), .WB_A(WB_A), .WB_D(WB_D),
    .WB_OPSTAGE(WB_OPSTAGE), .WB_RETN(WB_RETN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a write or a Q row.
  always @(negedge CLK) begin
    cycle++;
    if (WB_WEN === 1'b0) begin
      wenLow++;
      if (expWr.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        wr_exp_t e;
        e = expWr.pop_front();
        checkOutput("write_addr", DW'(WB_A[3:0]), DW'(e.addr));
        checkOutput("write_data", WB_D, e.data);
      end
    end
    if (WB_CEN === 1'b0) cenLow++;
    if ((WB_CEN === 1'b0) || (WB_WEN === 1'b0))
      checkOutput("addr_upper_zero", DW'(WB_A[AW-1:4]), 0);
    if (q_valid === 1'b1) begin
      qCount++;
      if (qFirst < 0) qFirst = cycle;
      qLast = cycle;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_q_valid", 1, 0);
      end else begin
        q_exp_t e;
        e = expQ.pop_front();
        checkOutput("q_row", DW'(q_row), DW'(e.row));
        checkOutput("q_last", DW'(q_last), DW'(e.last));
      end
      checkOutput("run_done_with_last", DW'(run_done), DW'(q_last));
    end
    if (load_done === 1'b1) loadDoneCnt++;
    if (run_done === 1'b1) runDoneCnt++;
  end

  // Load len rows with data base+i; optionally pair cmd_run with cmd_load
  // and/or pulse cmd_run during the load phase (both must be ignored).
  task automatic applyStimulus(input int len, input int base, input bit runWithLoad,
                               input bit runDuringLoad);
    int n;
    int sent;
    int w0;
    bit rdy;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      wr_exp_t e;
      e.addr = 4'(i);
      e.data = DW'(base + i);
      expWr.push_back(e);
    end
    w0 = wenLow;
    cmd_load = 1'b1;
    load_len = LW'(len);
    cmd_run  = runWithLoad;
    run_len  = 5'd3;
    run_passes = 4'd1;
    tick(1);
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    if (n == 0) return;
    checkOutput("load_ready_up", DW'(ld_ready), 1);
    sent = 0;
    for (int c = 0; c < 64 && sent < n; c++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(base + sent);
      if (runDuringLoad && c == 0) begin
        cmd_run = 1'b1;
        run_len = 5'd2;
      end
      rdy = ld_ready;
      tick(1);
      cmd_run = 1'b0;
      if (rdy) sent++;
    end
    ld_valid = 1'b0;
    checkOutput("load_all_sent", sent, n);
    checkOutput("load_ready_drop", DW'(ld_ready), 0);
    checkOutput("load_busy_tail", DW'(busy), 1);
    checkOutput("load_done_early", DW'(load_done), 0);
    tick(1);
    checkOutput("load_done_pulse", DW'(load_done), 1);
    checkOutput("load_busy_fall", DW'(busy), 0);
    tick(1);
    checkOutput("load_done_once", DW'(load_done), 0);
    checkOutput("load_write_count", wenLow - w0, n);
    checkOutput("load_writes_drained", expWr.size(), 0);
  endtask

  // Replay len rows x passes; holdCycles stall cycles follow the first issue.
  task automatic runRows(input int len, input int passes, input bit opst,
                         input int holdCycles);
    int L;
    int P;
    int rd0;
    int cen0;
    int q0;
    bit finished;
    L = (len > DEPTH) ? DEPTH : len;
    P = (passes == 0) ? 1 : passes;
    for (int p = 0; p < P && L > 0; p++)
      for (int r = 0; r < L; r++) begin
        q_exp_t e;
        e.row  = 4'(r);
        e.last = (p == P - 1) && (r == L - 1);
        expQ.push_back(e);
      end
    rd0 = runDoneCnt;
    cen0 = cenLow;
    q0 = qCount;
    qFirst = -1;
    cmd_run     = 1'b1;
    run_len     = LW'(len);
    run_passes  = 4'(passes);
    run_opstage = opst;
    tick(1);
    cmd_run = 1'b0;
    if (L == 0) begin
      checkOutput("zero_run_done", DW'(run_done), 1);
      checkOutput("zero_run_idle", DW'(busy), 0);
      tick(3);
      checkOutput("zero_run_no_read", cenLow - cen0, 0);
      checkOutput("zero_run_done_once", runDoneCnt - rd0, 1);
      return;
    end
    checkOutput("run_busy", DW'(busy), 1);
    checkOutput("run_cen_k", DW'(WB_CEN), 1);
    tick(1);
    checkOutput("run_first_issue", DW'(WB_CEN), 0);
    checkOutput("run_opstage", DW'(WB_OPSTAGE), DW'(opst));
    checkOutput("run_qvalid_k1", DW'(q_valid), 0);
    if (holdCycles > 0) hold = 1'b1;
    tick(1);
    checkOutput("run_qvalid_k2", DW'(q_valid), 1);
    if (holdCycles > 0) begin
      checkOutput("hold_cen_high", DW'(WB_CEN), 1);
      if (holdCycles > 1) tick(holdCycles - 1);
      checkOutput("hold_cen_high_end", DW'(WB_CEN), 1);
      hold = 1'b0;
    end
    finished = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (busy == 1'b0) begin
        finished = 1'b1;
        break;
      end
      tick(1);
    end
    checkOutput("run_finished", DW'(finished), 1);
    tick(1);
    checkOutput("run_q_drained", expQ.size(), 0);
    checkOutput("run_q_count", qCount - q0, L * P);
    checkOutput("run_q_span", qLast - qFirst + 1, L * P + holdCycles);
    checkOutput("run_cen_count", cenLow - cen0, L * P);
    checkOutput("run_done_count", runDoneCnt - rd0, 1);
  endtask

  initial begin
    int rd0;
    int q0;
    int cen0;
    RST = 1'b1;
    cmd_load = 1'b0;
    load_len = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    cmd_run = 1'b0;
    run_len = '0;
    run_passes = '0;
    run_opstage = 1'b0;
    hold = 1'b0;
    tick(2);
    checkOutput("rst_busy", DW'(busy), 0);
    checkOutput("rst_ld_ready", DW'(ld_ready), 0);
    checkOutput("rst_q_valid", DW'(q_valid), 0);
    checkOutput("rst_cen", DW'(WB_CEN), 1);
    checkOutput("rst_wen", DW'(WB_WEN), 1);
    checkOutput("rst_addr", DW'(WB_A), 0);
    checkOutput("rst_data", WB_D, 0);
    checkOutput("rst_retn", DW'(WB_RETN), 0);
    RST = 1'b0;
    tick(1);
    checkOutput("retn_after_reset", DW'(WB_RETN), 1);

    $display("[TB] load 4 rows");
    applyStimulus(4, 'hA0, 1'b0, 1'b0);

    $display("[TB] run len=4 passes=2 opstage=1");
    runRows(4, 2, 1'b1, 0);

    $display("[TB] run len=3 passes=1 with 2 hold cycles");
    runRows(3, 1, 1'b0, 2);

    $display("[TB] zero-length run, then over-length load");
    runRows(0, 1, 1'b1, 0);
    applyStimulus(20, 'h100, 1'b0, 1'b0);

    $display("[TB] load+run together, run during load");
    rd0 = runDoneCnt;
    cen0 = cenLow;
    applyStimulus(2, 'h200, 1'b1, 1'b1);
    tick(6);
    checkOutput("dropped_run_no_read", cenLow - cen0, 0);
    checkOutput("dropped_run_no_done", runDoneCnt - rd0, 0);
    checkOutput("dropped_run_idle", DW'(busy), 0);

    $display("[TB] reset during replay");
    begin
      q_exp_t e;
      e.last = 1'b0;
      e.row = 4'd0;
      expQ.push_back(e);
      e.row = 4'd1;
      expQ.push_back(e);
    end
    rd0 = runDoneCnt;
    q0 = qCount;
    cmd_run = 1'b1;
    run_len = 5'd6;
    run_passes = 4'd1;
    run_opstage = 1'b1;
    tick(1);
    cmd_run = 1'b0;
    tick(3);
    RST = 1'b1;
    tick(1);
    checkOutput("abort_cen", DW'(WB_CEN), 1);
    checkOutput("abort_q_valid", DW'(q_valid), 0);
    checkOutput("abort_busy", DW'(busy), 0);
    checkOutput("abort_run_done", DW'(run_done), 0);
    checkOutput("abort_opstage", DW'(WB_OPSTAGE), 0);
    RST = 1'b0;
    tick(4);
    checkOutput("abort_q_count", qCount - q0, 2);
    checkOutput("abort_q_drained", expQ.size(), 0);
    checkOutput("abort_no_done", runDoneCnt - rd0, 0);
    checkOutput("abort_retn_back", DW'(WB_RETN), 1);
    runRows(2, 1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
Sequencer for the 16-entry x 512-bit weight buffer. It accepts a valid/ready stream of weight rows and writes them into the buffer. It then replays the stored rows, one or more times, into the systolic array. It drives every buffer control pin (CEN, WEN, A, D, OPSTAGE, RETN) and returns a valid/last/row-index sideband aligned with the buffer's registered Q output.

Parameters:
DEPTH, 16, number of buffer entries (power of 2)
AW, 13, buffer address port width; upper bits driven 0
DW, 512, row width
LW, 5, length field width (must hold DEPTH)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
cmd_load  in  1  one-cycle pulse: start load phase
load_len  in  LW  rows to load, sampled with cmd_load
ld_valid  in  1  load stream valid
ld_ready  out  1  load stream ready
ld_data  in  DW  load stream row
load_done  out  1  one-cycle pulse: load phase complete
cmd_run  in  1  one-cycle pulse: start replay
run_len  in  LW  rows per pass, sampled with cmd_run
run_passes  in  4  pass count, sampled with cmd_run; 0 means 1
run_opstage  in  1  driven onto WB_OPSTAGE for whole run
hold  in  1  downstream stall; suspends read issue
run_done  out  1  one-cycle pulse: replay complete
busy  out  1  state != IDLE
q_valid  out  1  WB Q carries a replayed row this cycle
q_last  out  1  with q_valid: last row of last pass
q_row  out  LW-1  row index of current Q
WB_CEN  out  1  buffer chip enable, active-low
WB_WEN  out  1  buffer write enable, active-low
WB_A  out  AW  buffer address
WB_D  out  DW  buffer write data
WB_OPSTAGE  out  1  buffer opstage select
WB_RETN  out  1  buffer retention enable

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE; ld_ready=0; load_done=0; run_done=0; busy=0; q_valid=0; q_last=0; q_row=0.
  - WB_CEN=1; WB_WEN=1; WB_A=0; WB_D=0; WB_OPSTAGE=0; WB_RETN=0.
  - WB_RETN goes to 1 on the first edge with RST=0 and stays 1.
- States: IDLE, LOAD, READ, DRAIN.
- Length clamp: load_len and run_len values above DEPTH saturate to DEPTH.
- Zero length: len=0 moves to no phase; the matching done pulse is asserted on the next edge and the block stays IDLE.
- IDLE:
  - cmd_load -> LOAD.
  - cmd_run (without cmd_load) -> READ.
  - Both asserted together: load wins and the run command is dropped.
  - Commands arriving while busy=1 are ignored.
- LOAD:
  - ld_ready=1 throughout.
  - Each handshake (ld_valid & ld_ready) at edge t registers WB_WEN=0, WB_A=cnt, WB_D=ld_data for cycle t+1, then cnt++.
  - With no handshake, WB_WEN=1 and WB_D holds its value.
  - After the load_len-th handshake: ld_ready drops on that same edge; the next edge returns to IDLE with load_done=1 for one cycle.
  - WB_CEN stays 1 during LOAD.
- READ:
  - WB_OPSTAGE=run_opstage, latched at cmd_run.
  - Each edge with hold=0 registers WB_CEN=0, WB_A=cnt, and advances the counters.
  - Each edge with hold=1 registers WB_CEN=1; counters are frozen.
  - cnt wraps run_len-1 -> 0 and increments pass.
  - After issuing the last row of the last pass -> DRAIN.
- DRAIN: WB_CEN=1; one cycle; then IDLE with run_done=1.
- Read latency:
  - cmd_run sampled at edge k.
  - The first WB_CEN=0 is visible after edge k+1.
  - The buffer's Q and q_valid are both valid after edge k+2.
- Q sideband:
  - q_valid/q_row/q_last are the one-edge-delayed copy of (issue, cnt, final-issue).
  - run_done is asserted in the same cycle as the final q_valid.
  - The buffer returns 0 when CEN=1, so hold cycles yield q_valid=0 with Q=0.
- WB_OPSTAGE=0 produces constant rows of sixteen 1.0 floats from the buffer. Sequencing is unchanged; the controller does not inspect data.
- RST asserted mid-LOAD or mid-READ:
  - Next edge forces IDLE and all reset values.
  - No done pulse is issued.
  - Buffer contents are not touched.
- WB_A upper bits [AW-1:log2(DEPTH)] are always 0.

Test Plan:
1. Reset then cmd_load len=4, ld_valid held 1 with data 0xA0..0xA3 -> WB_WEN low 4 consecutive cycles, A=0..3; load_done pulses one cycle after last write; busy falls same edge.
2. Load 4 rows, then cmd_run len=4 passes=2 opstage=1, hold=0 -> q_valid high 8 consecutive cycles starting 2 cycles after cmd_run; q_row 0,1,2,3,0,1,2,3; q_last only on 8th; run_done coincident with 8th.
3. Run len=3 passes=1 with hold=1 for 2 cycles after the first issue -> WB_CEN high 2 cycles; q_valid gap of 2; q_row sequence 0,1,2 intact; total 5 Q cycles.
4. cmd_run len=0 -> run_done next cycle, WB_CEN never low. cmd_load len=20 -> exactly 16 writes, A=0..15.
5. cmd_load and cmd_run same cycle -> load phase only. cmd_run during LOAD ignored, with no READ afterwards.
6. RST asserted after 2 of 6 replay rows -> next cycle WB_CEN=1, q_valid=0, busy=0, no run_done. A subsequent run len=2 then completes normally.
